// File: rtl/operand_fetch_selector.sv
// Register file plus a start-triggered two-phase operand fetch sequencer.
// Operands are decoded from captured select codes and presented on a registered bus.
module operand_fetch_selector #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_REGS  = 8,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned PHASE_GAP = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  sel_1,
  input  logic [SEL_W-1:0]  sel_2,
  input  logic [WIDTH-1:0]  imm_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic [WIDTH-1:0]  operand_out,
  output logic              operand_valid,
  output logic              operand_index,
  output logic              done,
  output logic              sel_err
);

  typedef enum logic [1:0] {IDLE, PH1, GAP, PH2} state_t;

  localparam logic [3:0] GAP_LAST = 4'((PHASE_GAP == 0) ? 0 : PHASE_GAP - 1);

  state_t             state_q, state_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [SEL_W-1:0]   sel1_q, sel2_q;
  logic [WIDTH-1:0]   imm_q;
  logic [WIDTH-1:0]   regs_q [NUM_REGS];

  logic               wr_ok;
  logic               in_phase;
  logic [SEL_W-1:0]   cur_sel;
  int unsigned        code;
  logic [ADDR_W-1:0]  rd_idx;
  logic [WIDTH-1:0]   dec_data;
  logic               dec_err;

  assign busy     = (state_q != IDLE);
  assign wr_ok    = wr_en && (32'(wr_addr) < NUM_REGS);
  assign in_phase = (state_q == PH1) || (state_q == PH2);

  // Same-edge write to the decoded register wins over the stored value.
  always_comb begin
    cur_sel  = (state_q == PH2) ? sel2_q : sel1_q;
    code     = 32'(cur_sel);
    rd_idx   = ADDR_W'(code - 1);
    dec_data = '0;
    dec_err  = 1'b0;
    if (code == 0) begin
      dec_data = '0;
    end else if (code <= NUM_REGS) begin
      dec_data = regs_q[rd_idx];
      if (wr_ok && (wr_addr == rd_idx)) dec_data = wr_data;
    end else if (code == NUM_REGS + 1) begin
      dec_data = imm_q;
    end else begin
      dec_err = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: if (start) state_d = PH1;
      PH1: begin
        gap_cnt_d = '0;
        state_d   = (PHASE_GAP > 0) ? GAP : PH2;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = PH2;
        else gap_cnt_d = gap_cnt_q + 4'd1;
      end
      PH2: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      gap_cnt_q     <= '0;
      sel1_q        <= '0;
      sel2_q        <= '0;
      imm_q         <= '0;
      operand_out   <= '0;
      operand_valid <= 1'b0;
      operand_index <= 1'b0;
      done          <= 1'b0;
      sel_err       <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      gap_cnt_q <= gap_cnt_d;
      if (wr_ok) regs_q[wr_addr] <= wr_data;

      operand_valid <= in_phase;
      done          <= (state_q == PH2);
      if (in_phase) begin
        operand_out   <= dec_data;
        operand_index <= (state_q == PH2);
      end

      if (state_q == IDLE && start) begin
        sel1_q  <= sel_1;
        sel2_q  <= sel_2;
        imm_q   <= imm_data;
        sel_err <= 1'b0;
      end else if (in_phase && dec_err) begin
        sel_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch_selector.sv
// Randomised and directed bench for operand_fetch_selector against a transaction-level model.
// Instance 0: NUM_REGS=8, PHASE_GAP=1. Instance 1: NUM_REGS=6, PHASE_GAP=0.
module tb_operand_fetch_selector;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic [3:0]  sel_1, sel_2;
  logic [31:0] imm_data;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;

  logic [1:0]  busy_o, valid_o, idx_o, done_o, err_o;
  logic [31:0] op_o [2];

  int unsigned errors = 0;
  int unsigned checks = 0;

  operand_fetch_selector #(.WIDTH(32), .NUM_REGS(8), .SEL_W(4), .ADDR_W(3), .PHASE_GAP(1)) u_dut_a (
    .clock(clock), .reset_n(reset_n), .start(start), .sel_1(sel_1), .sel_2(sel_2),
    .imm_data(imm_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy_o[0]), .operand_out(op_o[0]), .operand_valid(valid_o[0]),
    .operand_index(idx_o[0]), .done(done_o[0]), .sel_err(err_o[0])
  );

  operand_fetch_selector #(.WIDTH(32), .NUM_REGS(6), .SEL_W(4), .ADDR_W(3), .PHASE_GAP(0)) u_dut_b (
    .clock(clock), .reset_n(reset_n), .start(start), .sel_1(sel_1), .sel_2(sel_2),
    .imm_data(imm_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy_o[1]), .operand_out(op_o[1]), .operand_valid(valid_o[1]),
    .operand_index(idx_o[1]), .done(done_o[1]), .sel_err(err_o[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: per instance, a fetch started at edge s yields operand 0 at edge s+1
  // and operand 1 at edge s+2+gap; writes at an edge are visible to that edge's decode.
  int unsigned m_nregs [2] = '{8, 6};
  int unsigned m_gap   [2] = '{1, 0};
  logic [31:0] m_regs  [2][8];
  bit          m_active[2];
  int unsigned m_st    [2];
  logic [3:0]  m_s1    [2];
  logic [3:0]  m_s2    [2];
  logic [31:0] m_imm   [2];
  logic [31:0] m_out   [2];
  bit          m_valid [2];
  bit          m_idx   [2];
  bit          m_done  [2];
  bit          m_err   [2];
  int unsigned edge_n = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_decode(input int k, input logic [3:0] sel,
                                   output logic [31:0] v, output bit err);
    int unsigned c;
    c   = sel;
    v   = '0;
    err = 1'b0;
    if (c == 0) v = '0;
    else if (c <= m_nregs[k]) v = m_regs[k][c-1];
    else if (c == m_nregs[k] + 1) v = m_imm[k];
    else err = 1'b1;
  endfunction

  function automatic void m_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) m_regs[k][i] = '0;
      m_active[k] = 0; m_st[k] = 0; m_s1[k] = '0; m_s2[k] = '0; m_imm[k] = '0;
      m_out[k] = '0; m_valid[k] = 0; m_idx[k] = 0; m_done[k] = 0; m_err[k] = 0;
    end
  endfunction

  function automatic void m_edge();
    logic [31:0] v;
    bit          e, acc;
    for (int k = 0; k < 2; k++) begin
      if (wr_en && (32'(wr_addr) < m_nregs[k])) m_regs[k][wr_addr] = wr_data;
      acc        = start && !m_active[k];
      m_valid[k] = 0;
      m_done[k]  = 0;
      if (m_active[k] && edge_n == m_st[k] + 1) begin
        m_decode(k, m_s1[k], v, e);
        m_out[k] = v; m_idx[k] = 0; m_valid[k] = 1;
        if (e) m_err[k] = 1;
      end
      if (m_active[k] && edge_n == m_st[k] + 2 + m_gap[k]) begin
        m_decode(k, m_s2[k], v, e);
        m_out[k] = v; m_idx[k] = 1; m_valid[k] = 1; m_done[k] = 1;
        if (e) m_err[k] = 1;
        m_active[k] = 0;
      end
      if (acc) begin
        m_active[k] = 1; m_st[k] = edge_n;
        m_s1[k] = sel_1; m_s2[k] = sel_2; m_imm[k] = imm_data; m_err[k] = 0;
      end
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("busy%0d", k),  busy_o[k],  m_active[k]);
      check($sformatf("valid%0d", k), valid_o[k], m_valid[k]);
      check($sformatf("op%0d", k),    op_o[k],    m_out[k]);
      check($sformatf("idx%0d", k),   idx_o[k],   m_idx[k]);
      check($sformatf("done%0d", k),  done_o[k],  m_done[k]);
      check($sformatf("err%0d", k),   err_o[k],   m_err[k]);
    end
  endtask

  task automatic step(input bit st, input logic [3:0] s1, input logic [3:0] s2,
                      input logic [31:0] imm, input bit we, input logic [2:0] wa,
                      input logic [31:0] wd);
    start = st; sel_1 = s1; sel_2 = s2; imm_data = imm;
    wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clock);
    edge_n++;
    m_edge();
    #1 compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nvalid;
    reset_n = 1'b0; start = 0; sel_1 = '0; sel_2 = '0; imm_data = '0;
    wr_en = 0; wr_addr = '0; wr_data = '0;
    m_reset();
    repeat (2) @(posedge clock);
    #1 compare_all();
    @(negedge clock) reset_n = 1'b1;

    // Basic fetch of reg[3], reg[4] on the gap=1 instance.
    step(0, 0, 0, 0, 1, 3, 32'h1234_5678);
    step(0, 0, 0, 0, 1, 4, 32'hCAFE_0001);
    step(1, 4, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("tp1_op0", op_o[0], 32'h1234_5678);
    check("tp1_busy_c3", busy_o[0], 1'b1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("tp1_op1", op_o[0], 32'hCAFE_0001);
    check("tp1_done", done_o[0], 1'b1);
    idle(2);

    // Immediate select, inputs changing after capture.
    step(1, 9, 0, 32'hDEAD_BEEF, 0, 0, 0);
    step(0, 3, 3, 32'h0BAD_F00D, 0, 0, 0);
    check("imm_op0", op_o[0], 32'hDEAD_BEEF);
    idle(4);

    // Undefined code on operand 1; next start clears sel_err.
    step(1, 1, 15, 0, 0, 0, 0);
    idle(4);
    check("err_held", err_o[0], 1'b1);
    step(1, 0, 0, 0, 0, 0, 0);
    check("err_cleared", err_o[0], 1'b0);
    idle(4);

    // Forwarding on the gap=0 instance: write reg[2] during PH2 reading sel 3.
    step(0, 0, 0, 0, 1, 2, 32'h11);
    step(1, 1, 3, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 0);
    step(0, 1, 3, 0, 1, 2, 32'h55AA);
    check("fwd_op1", op_o[1], 32'h55AA);
    idle(2);
    step(1, 3, 3, 0, 0, 0, 0);
    idle(3);
    check("fwd_later", op_o[1], 32'h55AA);

    // Dropped write beyond NUM_REGS on the 6-register instance.
    step(0, 0, 0, 0, 1, 6, 32'h7777_7777);
    idle(2);

    // Back-to-back with start held high: gap=0 instance gives four valids in six edges.
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)), $urandom, 0, 0, 0);
      if (valid_o[1]) nvalid++;
    end
    check("b2b_valids", nvalid, 4);
    idle(5);

    // Asynchronous reset while the gap=1 instance sits in GAP.
    step(1, 4, 5, 32'h1, 0, 0, 0);
    step(0, 4, 5, 32'h1, 0, 0, 0);
    check("pre_rst_busy", busy_o[0], 1'b1);
    #2 reset_n = 1'b0;
    #1;
    m_reset();
    check("rst_op", op_o[0], 32'h0);
    check("rst_busy", busy_o[0], 1'b0);
    check("rst_valid", valid_o[0], 1'b0);
    start = 0; wr_en = 0;
    @(posedge clock);
    #2 reset_n = 1'b1;
    idle(3);
    step(1, 4, 5, 0, 0, 0, 0);
    idle(3);
    check("rst_regs_zero", op_o[0], 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           $urandom, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom);
    end
    idle(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
